// File: rtl/ym2149_writer.sv
// Command-stream player for a YM2149 PSG: decodes register writes, sample waits and end-of-stream.
// Optional feature: define YM2149_WRITER_LOOP_EN to make 0x66 a loop marker instead of a terminal stop.
module ym2149_writer #(
   parameter int SAMPLE_DIV = 45,
   parameter int WR_CYCLES  = 2
) (
   input  logic       in_clk,
   input  logic       in_rst,
   input  logic [7:0] in_data,
   input  logic       in_valid,
   output logic       out_ready,
   output logic [3:0] out_reg,
   output logic [7:0] out_val,
   output logic       out_wr,
   output logic       out_done,
   output logic       out_err
);

   typedef enum logic [2:0] {
      S_OPCODE, S_ARG1, S_ARG2, S_WRITE_HI, S_WRITE_LO, S_WAIT, S_DONE
   } state_t;

   localparam logic [15:0] DIV_LAST = 16'(SAMPLE_DIV - 1);
   localparam logic [3:0]  WR_LAST  = 4'(WR_CYCLES - 1);

   state_t      r_state;
   logic        r_is_write;
   logic [7:0]  r_lo;
   logic [15:0] r_samples;
   logic [15:0] r_div;
   logic [3:0]  r_wr_cnt;
   logic [3:0]  r_reg;
   logic [7:0]  r_val;
   logic        r_wr;
   logic        r_done;
   logic        r_err;

   logic w_accepting;
   logic w_val_load;

   assign w_accepting = (r_state == S_OPCODE) || (r_state == S_ARG1) || (r_state == S_ARG2);
   assign out_ready   = w_accepting && !in_rst;

   // The value byte is forwarded while it is being accepted so out_val is settled a cycle before out_wr rises.
   assign w_val_load  = (r_state == S_ARG2) && r_is_write && in_valid && !in_rst;
   assign out_val     = w_val_load ? in_data : r_val;
   assign out_reg     = r_reg;
   assign out_wr      = r_wr;
   assign out_done    = r_done;
   assign out_err     = r_err;

   always_ff @(posedge in_clk) begin
      if (in_rst) begin
         r_state    <= S_OPCODE;
         r_is_write <= 1'b0;
         r_lo       <= 8'd0;
         r_samples  <= 16'd0;
         r_div      <= 16'd0;
         r_wr_cnt   <= 4'd0;
         r_reg      <= 4'd0;
         r_val      <= 8'd0;
         r_wr       <= 1'b0;
         r_done     <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         r_err <= 1'b0;
`ifdef YM2149_WRITER_LOOP_EN
         r_done <= 1'b0;
`endif
         case (r_state)
            S_OPCODE: begin
               if (in_valid) begin
                  if (in_data == 8'hA0) begin
                     r_is_write <= 1'b1;
                     r_state    <= S_ARG1;
                  end else if (in_data == 8'h61) begin
                     r_is_write <= 1'b0;
                     r_state    <= S_ARG1;
                  end else if (in_data == 8'h62) begin
                     r_samples <= 16'd735;
                     r_div     <= 16'd0;
                     r_state   <= S_WAIT;
                  end else if (in_data == 8'h63) begin
                     r_samples <= 16'd882;
                     r_div     <= 16'd0;
                     r_state   <= S_WAIT;
                  end else if (in_data[7:4] == 4'h7) begin
                     r_samples <= {12'd0, in_data[3:0]} + 16'd1;
                     r_div     <= 16'd0;
                     r_state   <= S_WAIT;
                  end else if (in_data == 8'h66) begin
                     r_done <= 1'b1;
`ifndef YM2149_WRITER_LOOP_EN
                     r_state <= S_DONE;
`endif
                  end else begin
                     r_err <= 1'b1;
                  end
               end
            end
            S_ARG1: begin
               if (in_valid) begin
                  r_lo <= in_data;
                  if (r_is_write) begin
                     r_reg <= in_data[3:0];
                  end
                  r_state <= S_ARG2;
               end
            end
            S_ARG2: begin
               if (in_valid) begin
                  if (r_is_write) begin
                     r_val    <= in_data;
                     r_wr     <= 1'b1;
                     r_wr_cnt <= 4'd0;
                     r_state  <= S_WRITE_HI;
                  end else begin
                     r_samples <= {in_data, r_lo};
                     r_div     <= 16'd0;
                     r_state   <= S_WAIT;
                  end
               end
            end
            S_WRITE_HI: begin
               if (r_wr_cnt == WR_LAST) begin
                  r_wr     <= 1'b0;
                  r_wr_cnt <= 4'd0;
                  r_state  <= S_WRITE_LO;
               end else begin
                  r_wr_cnt <= r_wr_cnt + 4'd1;
               end
            end
            S_WRITE_LO: begin
               if (r_wr_cnt == WR_LAST) begin
                  r_wr_cnt <= 4'd0;
                  r_state  <= S_OPCODE;
               end else begin
                  r_wr_cnt <= r_wr_cnt + 4'd1;
               end
            end
            S_WAIT: begin
               // Zero-sample waits still spend one cycle here.
               if ((r_samples == 16'd0) || ((r_samples == 16'd1) && (r_div == DIV_LAST))) begin
                  r_div   <= 16'd0;
                  r_state <= S_OPCODE;
               end else if (r_div == DIV_LAST) begin
                  r_div     <= 16'd0;
                  r_samples <= r_samples - 16'd1;
               end else begin
                  r_div <= r_div + 16'd1;
               end
            end
            S_DONE: begin
               r_state <= S_DONE;
            end
            default: begin
               r_state <= S_OPCODE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ym2149_writer.sv
// Self-checking bench for ym2149_writer: directed scenarios plus randomized commands against a cycle-count model.
module tb_ym2149_writer;

   localparam int SAMPLE_DIV = 45;
   localparam int WR_CYCLES  = 2;

   logic       in_clk = 1'b0;
   logic       in_rst;
   logic [7:0] in_data;
   logic       in_valid;
   logic       out_ready;
   logic [3:0] out_reg;
   logic [7:0] out_val;
   logic       out_wr;
   logic       out_done;
   logic       out_err;

   int n_checks = 0;
   int n_fail   = 0;
   logic [3:0] exp_reg = 4'd0;
   logic [7:0] exp_val = 8'd0;

   ym2149_writer #(.SAMPLE_DIV(SAMPLE_DIV), .WR_CYCLES(WR_CYCLES)) dut (
      .in_clk   (in_clk),
      .in_rst   (in_rst),
      .in_data  (in_data),
      .in_valid (in_valid),
      .out_ready(out_ready),
      .out_reg  (out_reg),
      .out_val  (out_val),
      .out_wr   (out_wr),
      .out_done (out_done),
      .out_err  (out_err)
   );

   always #5 in_clk = ~in_clk;

   task automatic check(input string tag, input int obs, input int expv);
      n_checks++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(posedge in_clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      int guard = 0;
      in_data  = b;
      in_valid = 1'b1;
      while (out_ready !== 1'b1 && guard < 50000) begin
         tick();
         guard++;
      end
      if (guard >= 50000) check("ready_timeout", 0, 1);
      tick();
      in_valid = 1'b0;
      in_data  = 8'($urandom);
   endtask

   task automatic idle(input int n);
      int bad = 0;
      in_valid = 1'b0;
      for (int i = 0; i < n; i++) begin
         if (out_ready !== 1'b1 || out_wr !== 1'b0) bad++;
         tick();
      end
      if (n > 0) check("idle_ready", bad, 0);
   endtask

   // Counts not-ready cycles after a command and checks the strobe profile cycle by cycle.
   task automatic measure(input string tag, input int exp_busy, input int exp_hi);
      int busy = 0;
      int bad  = 0;
      while (out_ready !== 1'b1 && busy < 40000) begin
         if (out_wr !== ((busy < exp_hi) ? 1'b1 : 1'b0)) bad++;
         if (out_reg !== exp_reg || out_val !== exp_val || out_err !== 1'b0 || out_done !== 1'b0) bad++;
         busy++;
         tick();
      end
      check({tag, "_busy"}, busy, exp_busy);
      check({tag, "_profile"}, bad, 0);
      check({tag, "_wr_after"}, int'(out_wr), 0);
      $display("%s: busy %0d cycles, model %0d, reg %0h val %0h", tag, busy, exp_busy, out_reg, out_val);
   endtask

   task automatic run_write(input logic [7:0] aa, input logic [7:0] dd, input int stall);
      send_byte(8'hA0);
      idle(stall);
      send_byte(aa);
      idle(stall);
      send_byte(dd);
      exp_reg = aa[3:0];
      exp_val = dd;
      measure("write", 2 * WR_CYCLES, WR_CYCLES);
      check("write_reg", int'(out_reg), int'(aa[3:0]));
      check("write_val", int'(out_val), int'(dd));
   endtask

   task automatic run_wait(input logic [7:0] op, input logic [7:0] lo, input logic [7:0] hi, input int stall);
      int n;
      int expb;
      if (op == 8'h61)      n = int'(hi) * 256 + int'(lo);
      else if (op == 8'h62) n = 735;
      else if (op == 8'h63) n = 882;
      else                  n = int'(op[3:0]) + 1;
      expb = (n == 0) ? 1 : n * SAMPLE_DIV;
      send_byte(op);
      if (op == 8'h61) begin
         idle(stall);
         send_byte(lo);
         idle(stall);
         send_byte(hi);
      end
      measure("wait", expb, 0);
   endtask

   task automatic run_err(input logic [7:0] op);
      send_byte(op);
      check("err_pulse", int'(out_err), 1);
      check("err_ready", int'(out_ready), 1);
      tick();
      check("err_clear", int'(out_err), 0);
      $display("error opcode %0h: err %0b", op, out_err);
   endtask

   initial begin
      int bad;
      logic [7:0] op;
      in_rst   = 1'b1;
      in_valid = 1'b0;
      in_data  = 8'h00;
      repeat (3) tick();
      check("rst_ready", int'(out_ready), 0);
      check("rst_wr", int'(out_wr), 0);
      check("rst_reg", int'(out_reg), 0);
      check("rst_val", int'(out_val), 0);
      check("rst_done", int'(out_done), 0);
      check("rst_err", int'(out_err), 0);
      in_rst = 1'b0;
      #1;
      check("post_rst_ready", int'(out_ready), 1);

      run_write(8'h07, 8'h38, 0);
      run_wait(8'h61, 8'h03, 8'h00, 0);
      run_wait(8'h7F, 8'h00, 8'h00, 0);
      run_wait(8'h61, 8'h00, 8'h00, 0);
      run_wait(8'h62, 8'h00, 8'h00, 0);

      send_byte(8'hA0);
      idle(10);
      send_byte(8'h0F);
      idle(5);
      send_byte(8'hFF);
      exp_reg = 4'hF;
      exp_val = 8'hFF;
      measure("stall_write", 2 * WR_CYCLES, WR_CYCLES);

      run_err(8'h55);
      run_write(8'hF3, 8'h5A, 0);

      send_byte(8'hA0);
      send_byte(8'h07);
      send_byte(8'h38);
      check("midwr_high", int'(out_wr), 1);
      in_rst = 1'b1;
      tick();
      check("midwr_wr", int'(out_wr), 0);
      check("midwr_ready", int'(out_ready), 0);
      check("midwr_reg", int'(out_reg), 0);
      in_rst = 1'b0;
      #1;
      check("midwr_ready_after", int'(out_ready), 1);
      exp_reg = 4'd0;
      exp_val = 8'd0;
      run_write(8'h01, 8'h02, 0);

      for (int i = 0; i < 20; i++) begin
         case ($urandom_range(0, 3))
            0: run_write(8'($urandom), 8'($urandom), $urandom_range(0, 3));
            1: run_wait(8'h61, 8'($urandom_range(0, 20)), 8'h00, $urandom_range(0, 3));
            2: run_wait({4'h7, 4'($urandom)}, 8'h00, 8'h00, 0);
            default: begin
               op = 8'($urandom);
               while (op == 8'hA0 || op == 8'h61 || op == 8'h62 || op == 8'h63 ||
                      op == 8'h66 || op[7:4] == 4'h7) begin
                  op = 8'($urandom);
               end
               run_err(op);
            end
         endcase
      end

      send_byte(8'h66);
`ifdef YM2149_WRITER_LOOP_EN
      check("loop_done_pulse", int'(out_done), 1);
      check("loop_ready", int'(out_ready), 1);
      tick();
      check("loop_done_clear", int'(out_done), 0);
      run_write(8'h05, 8'hA5, 0);
`else
      bad = 0;
      in_valid = 1'b1;
      for (int i = 0; i < 20; i++) begin
         in_data = 8'($urandom);
         if (out_done !== 1'b1 || out_ready !== 1'b0 || out_wr !== 1'b0) bad++;
         tick();
      end
      in_valid = 1'b0;
      check("done_hold", bad, 0);
      $display("end of stream: done %0b ready %0b", out_done, out_ready);
      in_rst = 1'b1;
      tick();
      in_rst = 1'b0;
      #1;
      check("done_cleared", int'(out_done), 0);
      check("done_rst_ready", int'(out_ready), 1);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/ym2149_writer.md
YM2149_WRITER -- requirements
Module: ym2149_writer

Interface
REQ-001 SHALL have parameter SAMPLE_DIV, default 45, meaning the number of in_clk cycles per 44.1 kHz sample; legal range 1..65535.
REQ-002 SHALL have parameter WR_CYCLES, default 2, meaning the cycles out_wr is held high and then held low per write; legal range 1..15.
REQ-003 SHALL have port in_clk, input, 1 bit: the single clock; all logic rises on its edge.
REQ-004 SHALL have port in_rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port in_data, input, 8 bits: command stream byte.
REQ-006 SHALL have port in_valid, input, 1 bit: in_data is valid.
REQ-007 SHALL have port out_ready, output, 1 bit: the block accepts a byte this cycle.
REQ-008 SHALL have port out_reg, output, 4 bits: PSG register index.
REQ-009 SHALL have port out_val, output, 8 bits: PSG register value.
REQ-010 SHALL have port out_wr, output, 1 bit: write strobe; the PSG latches on its rising edge.
REQ-011 SHALL have port out_done, output, 1 bit: end-of-stream reached.
REQ-012 SHALL have port out_err, output, 1 bit: one-cycle pulse on an unknown opcode.

Function
REQ-013 SHALL transfer a byte only on a cycle where in_valid=1 and out_ready=1.
REQ-014 SHALL drive out_ready=1 only in states OPCODE, ARG1 and ARG2, and 0 in WRITE_HI, WRITE_LO, WAIT and DONE.
REQ-015 SHALL decode 0xA0 aa dd as a PSG write: out_reg=aa[3:0] (aa[7:4] ignored) and out_val=dd.
REQ-016 SHALL decode 0x61 lo hi as a wait of {hi,lo} samples.
REQ-017 SHALL decode 0x62 as a 735-sample wait, 0x63 as an 882-sample wait, and 0x70..0x7F as a wait of (n+1) samples, where n is the low nibble.
REQ-018 SHALL decode 0x66 as end-of-stream.
REQ-019 SHALL, for any other opcode, pulse out_err for 1 cycle, discard the byte and remain in OPCODE.
REQ-020 SHALL use the state transitions:
- OPCODE->ARG1 for 0xA0/0x61.
- ARG1->ARG2.
- ARG2->WRITE_HI for 0xA0, ARG2->WAIT for 0x61.
- OPCODE->WAIT for 0x62/0x63/0x7n.
- WRITE_HI->WRITE_LO->OPCODE.
- WAIT->OPCODE.
- OPCODE->DONE for 0x66.
REQ-021 SHALL assert out_wr=1 on the cycle after the dd byte is accepted and hold it for exactly WR_CYCLES cycles (WRITE_HI), then hold out_wr=0 for exactly WR_CYCLES cycles (WRITE_LO) before returning to OPCODE.
REQ-022 SHALL keep out_reg and out_val stable from one cycle before out_wr rises until the next write command loads them.
REQ-023 SHALL implement a wait of N samples as N*SAMPLE_DIV cycles in WAIT using a 16-bit sample counter and a 16-bit divider counter, with no overflow for N=65535.
REQ-024 SHALL complete a wait of N=0 (0x61 00 00) with 1 cycle in WAIT.
REQ-025 SHALL leave out_reg, out_val and out_wr unchanged during WAIT.
REQ-026 SHALL, in DONE, drive out_done=1 and out_ready=0 and keep out_wr=0.
REQ-027 SHALL consume stalls (in_valid=0) in ARG1/ARG2 without timeout, holding the partial command indefinitely.

Reset
REQ-028 SHALL, while in_rst=1 at a clock edge, set state to OPCODE, out_ready=0 on that cycle, out_wr=0, out_reg=0, out_val=0, out_done=0, out_err=0, and all counters to 0.
REQ-029 SHALL give reset priority over every event, including mid-write (out_wr falls on the next edge) and mid-wait (the wait is abandoned).
REQ-030 SHALL drive out_ready=1 on the first cycle after in_rst deasserts.

Configuration
REQ-031 SHALL, when macro YM2149_WRITER_LOOP_EN is defined, treat 0x66 as a loop marker: pulse out_done for 1 cycle and stay in OPCODE accepting bytes.
REQ-032 SHALL, when YM2149_WRITER_LOOP_EN is undefined, enter DONE on 0x66 and remain there until reset.

Verification
REQ-033 SHALL cover a write: bytes A0 07 38 with in_valid held high, WR_CYCLES=2 -> out_reg=7, out_val=0x38, out_wr high for 2 cycles starting the cycle after byte 38, low for 2 cycles, then out_ready=1.
REQ-034 SHALL cover a wait: bytes 61 03 00 with SAMPLE_DIV=45 -> out_ready=0 for exactly 135 cycles, then 1.
REQ-035 SHALL cover short waits: 0x7F -> 16*45=720 cycles; 0x62 -> 33075 cycles; 61 00 00 -> 1 cycle.
REQ-036 SHALL cover stall and error: A0, idle 10 cycles, 0F, idle 5, FF -> out_reg=15, out_val=0xFF; a later byte 0x55 -> out_err pulses 1 cycle and the next command decodes normally.
REQ-037 SHALL cover end-of-stream: 0x66 -> with the macro undefined, out_done=1 and out_ready=0 until in_rst; with the macro defined, a 1-cycle out_done pulse and out_ready=1 on the next cycle.
REQ-038 SHALL cover reset mid-write: in_rst asserted on the first out_wr-high cycle -> out_wr=0 and state OPCODE on the next edge, and the following A0 01 02 executes correctly.
